gsensor_spi_master: RTL and testbench
=====================================

// Module: gsensor_spi_master
// PURPOSE
//  SPI initiator for the on-board ADXL345 accelerometer (GSENSOR_* pins): the reader/writer end of the
//  sensor's SPI responder. Runs single-byte register writes and 1..6 byte register reads (multi-byte
//  for the DATAX0..DATAZ1 burst). Sits under the top level: clocked by the 50 MHz board clock, drives
//  GSENSOR_CS_N/SCLK/SDI, samples GSENSOR_SDO. 4-wire SPI, mode 3 (CPOL=1, CPHA=1), MSB first.
// PARAMETERS
//  CLK_DIV   10   system cycles per SCLK half-period; SCLK = f_clk/(2*CLK_DIV) = 2.5 MHz at 50 MHz; >=2
//  MAX_LEN   6    maximum bytes per read burst
// PORTS
//  CLK          in   1  system clock (MAX10_CLK1_50)
//  RESET_N      in   1  asynchronous reset, active low
//  START        in   1  request; accepted only when BUSY=0
//  RW           in   1  1=read, 0=write; sampled with START
//  ADDR         in   6  register address; sampled with START
//  LEN          in   3  read byte count 1..MAX_LEN; sampled with START
//  WDATA        in   8  write byte; sampled with START
//  BUSY         out  1  transaction in progress
//  DONE         out  1  one-cycle pulse at transaction end
//  RDATA        out  8  last received byte
//  RVALID       out  1  one-cycle pulse per received byte (reads only)
//  SPI_CS_N     out  1  to GSENSOR_CS_N
//  SPI_SCLK     out  1  to GSENSOR_SCLK
//  SPI_MOSI     out  1  to GSENSOR_SDI
//  SPI_MISO     in   1  from GSENSOR_SDO
// BEHAVIOUR
//  Reset: one clock; reset is asynchronous and active-low. Asserted -> immediately SPI_CS_N=1,
//   SPI_SCLK=1, SPI_MOSI=0, BUSY=0, DONE=0, RVALID=0, RDATA=8'h00, FSM=IDLE, counters 0. Mid-transfer
//   reset aborts at once; no partial RVALID/DONE afterwards.
//  Header byte: {RW, MB, ADDR}; MB=1 iff read with effective LEN>1. Length rules: LEN=0 -> 1;
//   LEN>MAX_LEN -> MAX_LEN; writes always 1 data byte (LEN ignored, MB=0).
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//   IDLE : BUSY=0. START=1 at edge -> latch inputs, CS_N=0, MOSI=header[7], BUSY=1 next cycle.
//   SETUP: CLK_DIV cycles, SCLK=1 (CS-to-first-edge setup).
//   SHIFT: 8*(1+n) bits; per bit SCLK low CLK_DIV cycles then high CLK_DIV cycles. MOSI updates on
//          each falling edge (except bit 0, presented in IDLE->SETUP). MISO sampled on each rising
//          edge. Data-phase MOSI = WDATA for writes, 0 for reads. Header-phase MISO discarded.
//   HOLD : CLK_DIV cycles, SCLK=1, CS_N=0.
//   GAP  : 2*CLK_DIV cycles, CS_N=1 (>=150 ns CS high between transfers). On exit BUSY=0, DONE=1 same cycle.
//  Read bytes: after 8th rising edge of each data byte, RDATA updated and RVALID pulses next cycle.
//  Timing (CLK_DIV=10): 1-byte txn BUSY = 10+320+10+20 = 360 cycles; 6-byte read = 10+1120+30 = 1160.
//  START while BUSY=1 ignored (not queued). START in DONE cycle is accepted (BUSY already 0).
//  SCLK never toggles outside SHIFT; SCLK idles high; CS_N low only in SETUP/SHIFT/HOLD.
// STRUCTURE
//  Shared include gsensor_defs.vh: FSM state encodings, ADXL345 register addresses (DEVID 6'h00,
//   BW_RATE 6'h2C, POWER_CTL 6'h2D, DATA_FORMAT 6'h31, DATAX0 6'h32), DEVID value 8'hE5.
//  Sub-module spi_tick_gen: CLK_DIV down-counter, enable + half-period tick; reset/restart on START.
//  Top level wires SPI_MOSI->GSENSOR_SDI, GSENSOR_SDO->SPI_MISO; other GSENSOR inout pins left Z.
// TESTING (bench has an ADXL345 SPI responder model, mode 3)
//  Reset: hold RESET_N=0 -> CS_N=1, SCLK=1, BUSY=0, DONE=0, RVALID=0, RDATA=00; assert async mid-cycle.
//  Read DEVID: START,RW=1,ADDR=00,LEN=1 -> MOSI 8'h80 then 8'h00, 16 SCLK rises, period 20 cycles,
//   RDATA=E5 with one RVALID, DONE at cycle 360, BUSY high exactly 360 cycles.
//  Write POWER_CTL: RW=0,ADDR=2D,WDATA=08 -> model sees 16'h2D08; no RVALID; DONE after 360 cycles.
//  Burst read: RW=1,ADDR=32,LEN=6, model returns 01..06 -> header F2, six RVALID with RDATA 01..06
//   in order, DONE once at cycle 1160; LEN=7 behaves identically; LEN=0 behaves as LEN=1.
//  Collision: START pulsed repeatedly during BUSY -> ignored, exactly one transaction; START on DONE
//   cycle -> second transaction begins next cycle.
//  Reset mid-SHIFT (after 5 bits): CS_N=1,SCLK=1 immediately, no DONE/RVALID; following DEVID read passes.

Source files
------------

// File: rtl/gsensor_spi_master_pkg.sv
// Shared definitions for the ADXL345 SPI initiator.
// Holds the FSM state encoding, the ADXL345 register map entries the
// firmware touches, the expected DEVID value, and the burst-length
// normalisation helper.
package gsensor_spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam logic [5:0] REG_DEVID       = 6'h00;
    localparam logic [5:0] REG_BW_RATE     = 6'h2C;
    localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
    localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
    localparam logic [5:0] REG_DATAX0      = 6'h32;

    localparam logic [7:0] DEVID_VALUE     = 8'hE5;

    // Number of data bytes actually moved: writes are always one byte,
    // a read of 0 is treated as 1, and reads are clipped to max_len.
    function automatic logic [2:0] eff_len(input logic       rw,
                                           input logic [2:0] len,
                                           input logic [2:0] max_len);
        if (!rw)
            return 3'd1;
        if (len == 3'd0)
            return 3'd1;
        if (len > max_len)
            return max_len;
        return len;
    endfunction

endpackage

// File: rtl/gsensor_spi_master_tick_gen.sv
// Half-period tick generator for the SPI initiator.
// A down-counter reloaded with CLK_DIV-1; tick is high for one cycle each
// time the counter reaches zero while enabled, i.e. every CLK_DIV cycles.
// Ports:
//   clk     system clock
//   rst_n   asynchronous reset, active low
//   restart reload the counter (transaction accepted)
//   en      counting enable (transaction in progress)
//   tick    one-cycle pulse marking the end of a half-period
module gsensor_spi_master_tick_gen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W  = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= RELOAD;
        end else if (en) begin
            if (cnt == '0)
                cnt <= RELOAD;
            else
                cnt <= cnt - 1'b1;
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/gsensor_spi_master.sv
// SPI initiator (mode 3, MSB first) for the on-board ADXL345 accelerometer.
// Performs single-byte register writes and 1..MAX_LEN byte register reads.
// Ports:
//   CLK, RESET_N        system clock, asynchronous active-low reset
//   START/RW/ADDR/LEN/WDATA  request and its arguments, sampled when idle
//   BUSY, DONE          transaction in progress, one-cycle end pulse
//   RDATA, RVALID       last received byte, one-cycle pulse per byte
//   SPI_CS_N/SCLK/MOSI  to GSENSOR_CS_N/SCLK/SDI
//   SPI_MISO            from GSENSOR_SDO
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | CS_N high, SCLK high, waiting for START
// ST_SETUP | CS_N low, one half-period before the first SCLK fall
// ST_SHIFT | header + data bits, SCLK low half then high half per bit
// ST_HOLD  | SCLK high, CS_N still low for one half-period
// ST_GAP   | CS_N high for two half-periods, then DONE
module gsensor_spi_master
    import gsensor_spi_master_pkg::*;
#(
    parameter int CLK_DIV = 10,
    parameter int MAX_LEN = 6
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       START,
    input  logic       RW,
    input  logic [5:0] ADDR,
    input  logic [2:0] LEN,
    input  logic [7:0] WDATA,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RDATA,
    output logic       RVALID,
    output logic       SPI_CS_N,
    output logic       SPI_SCLK,
    output logic       SPI_MOSI,
    input  logic       SPI_MISO
);

    localparam logic [2:0] MAX_LEN_L = 3'(MAX_LEN);

    state_t      state;
    logic        tick;
    logic        accept;
    logic [2:0]  n_bytes;
    logic [7:0]  header;
    logic [5:0]  bit_idx;
    logic [5:0]  last_bit;
    logic [14:0] tx_sr;     // bits still to be presented after the current MOSI bit
    logic [6:0]  rx_sr;
    logic        is_read;
    logic        gap_half;

    assign accept  = (state == ST_IDLE) && START;
    assign n_bytes = eff_len(RW, LEN, MAX_LEN_L);
    assign header  = {RW, RW && (n_bytes > 3'd1), ADDR};

    gsensor_spi_master_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .restart (accept),
        .en      (state != ST_IDLE),
        .tick    (tick)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            SPI_CS_N <= 1'b1;
            SPI_SCLK <= 1'b1;
            SPI_MOSI <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            RVALID   <= 1'b0;
            RDATA    <= 8'h00;
            bit_idx  <= '0;
            last_bit <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            is_read  <= 1'b0;
            gap_half <= 1'b0;
        end else begin
            DONE   <= 1'b0;
            RVALID <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        tx_sr    <= {header[6:0], (RW ? 8'h00 : WDATA)};
                        SPI_MOSI <= header[7];
                        SPI_CS_N <= 1'b0;
                        BUSY     <= 1'b1;
                        is_read  <= RW;
                        // total bits = 8*(1+n) so the last index is {n, 3'b111}
                        last_bit <= {n_bytes, 3'b111};
                        bit_idx  <= '0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        SPI_SCLK <= 1'b0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (!SPI_SCLK) begin
                            SPI_SCLK <= 1'b1;
                            rx_sr    <= {rx_sr[5:0], SPI_MISO};
                            // eighth bit of a data byte (header byte is bit_idx 0..7)
                            if (is_read && (bit_idx[5:3] != 3'd0) && (bit_idx[2:0] == 3'b111)) begin
                                RDATA  <= {rx_sr, SPI_MISO};
                                RVALID <= 1'b1;
                            end
                        end else if (bit_idx == last_bit) begin
                            state <= ST_HOLD;
                        end else begin
                            SPI_SCLK <= 1'b0;
                            SPI_MOSI <= tx_sr[14];
                            tx_sr    <= {tx_sr[13:0], 1'b0};
                            bit_idx  <= bit_idx + 6'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        SPI_CS_N <= 1'b1;
                        SPI_MOSI <= 1'b0;
                        gap_half <= 1'b0;
                        state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (gap_half) begin
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            gap_half <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gsensor_spi_master.sv
module tb_gsensor_spi_master;
    import gsensor_spi_master_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       START = 1'b0;
    logic       RW = 1'b0;
    logic [5:0] ADDR = 6'h00;
    logic [2:0] LEN = 3'd0;
    logic [7:0] WDATA = 8'h00;
    logic       BUSY, DONE, RVALID, SPI_CS_N, SPI_SCLK, SPI_MOSI;
    logic [7:0] RDATA;
    logic       SPI_MISO = 1'b0;

    gsensor_spi_master #(.CLK_DIV(10), .MAX_LEN(6)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .START    (START),
        .RW       (RW),
        .ADDR     (ADDR),
        .LEN      (LEN),
        .WDATA    (WDATA),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .RDATA    (RDATA),
        .RVALID   (RVALID),
        .SPI_CS_N (SPI_CS_N),
        .SPI_SCLK (SPI_SCLK),
        .SPI_MOSI (SPI_MOSI),
        .SPI_MISO (SPI_MISO)
    );

    always #5 CLK = ~CLK;

    int         n_cmp = 0;
    int         n_mis = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_byte;
    int         done_cnt = 0;
    int         rvalid_cnt = 0;

    // ---------------- ADXL345 responder model (mode 3) ----------------
    logic [7:0] mem [64];
    int         bitn = 0;
    int         rises = 0;
    int         cs_falls = 0;
    logic [7:0] m_shift = 8'h00;
    logic [7:0] m_hdr = 8'h00;
    logic [15:0] m_word = 16'h0000;
    longint     cyc_now = 0;
    longint     last_rise = -1;
    longint     per_min = 0;
    longint     per_max = 0;
    int         m_bi;
    logic [5:0] m_addr;

    always @(posedge CLK) cyc_now++;

    always @(negedge SPI_CS_N) begin
        bitn      = 0;
        rises     = 0;
        cs_falls++;
        last_rise = -1;
        per_min   = 1 << 30;
        per_max   = 0;
    end

    always @(posedge SPI_SCLK) begin
        if (SPI_CS_N === 1'b0) begin
            m_shift = {m_shift[6:0], SPI_MOSI};
            rises++;
            if (last_rise >= 0) begin
                if (cyc_now - last_rise < per_min) per_min = cyc_now - last_rise;
                if (cyc_now - last_rise > per_max) per_max = cyc_now - last_rise;
            end
            last_rise = cyc_now;
            bitn++;
            if (bitn == 8) m_hdr = m_shift;
            if (bitn == 16) begin
                m_word = {m_hdr, m_shift};
                if (!m_hdr[7]) mem[m_hdr[5:0]] = m_shift;
            end
        end
    end

    always @(negedge SPI_SCLK) begin
        if (SPI_CS_N === 1'b0) begin
            if (bitn >= 8 && m_hdr[7]) begin
                m_bi     = (bitn - 8) / 8;
                m_addr   = m_hdr[6] ? (m_hdr[5:0] + 6'(m_bi)) : m_hdr[5:0];
                SPI_MISO = mem[m_addr][7 - (bitn % 8)];
            end else begin
                SPI_MISO = 1'b0;
            end
        end
    end

    // ---------------- output monitor / scoreboard ----------------
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (DONE === 1'b1) done_cnt++;
            if (RVALID === 1'b1) begin
                rvalid_cnt++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL rdata_unexpected: RDATA=%h but no byte was expected", RDATA);
                end else begin
                    exp_byte = exp_q.pop_front();
                    if (RDATA !== exp_byte) begin
                        n_mis++;
                        $display("FAIL rdata: got %h expected %h", RDATA, exp_byte);
                    end
                end
            end
        end
    end

    // Issue one request and wait for BUSY to fall; returns at the negedge
    // where BUSY is first seen low (the DONE cycle).
    task automatic run_txn(input logic rw, input logic [5:0] addr, input logic [2:0] len,
                           input logic [7:0] wdata, output int busy_cyc, output logic done_seen);
        @(negedge CLK);
        RW = rw; ADDR = addr; LEN = len; WDATA = wdata; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        busy_cyc = 0;
        while (BUSY === 1'b1 && busy_cyc < 5000) begin
            busy_cyc++;
            @(negedge CLK);
        end
        done_seen = DONE;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        #23;
        n_cmp++; if (SPI_CS_N !== 1'b1) begin n_mis++; $display("FAIL reset_cs_n: got %b expected 1", SPI_CS_N); end
        n_cmp++; if (SPI_SCLK !== 1'b1) begin n_mis++; $display("FAIL reset_sclk: got %b expected 1", SPI_SCLK); end
        n_cmp++; if (SPI_MOSI !== 1'b0) begin n_mis++; $display("FAIL reset_mosi: got %b expected 0", SPI_MOSI); end
        n_cmp++; if (BUSY !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        n_cmp++; if (DONE !== 1'b0) begin n_mis++; $display("FAIL reset_done: got %b expected 0", DONE); end
        n_cmp++; if (RVALID !== 1'b0) begin n_mis++; $display("FAIL reset_rvalid: got %b expected 0", RVALID); end
        n_cmp++; if (RDATA !== 8'h00) begin n_mis++; $display("FAIL reset_rdata: got %h expected 00", RDATA); end
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    task automatic check_txn(input string name, input logic rw, input logic [5:0] addr,
                             input logic [2:0] len, input logic [7:0] wdata, input logic [15:0] exp_word,
                             input int exp_busy, input int exp_rv, input int exp_rises);
        int bc;
        logic dn;
        int rv0, d0;
        rv0 = rvalid_cnt;
        d0  = done_cnt;
        run_txn(rw, addr, len, wdata, bc, dn);
        n_cmp++; if (bc != exp_busy) begin n_mis++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, bc, exp_busy); end
        n_cmp++; if (dn !== 1'b1) begin n_mis++; $display("FAIL %s_done_at_end: got %b expected 1", name, dn); end
        repeat (3) @(negedge CLK);
        n_cmp++; if (m_word !== exp_word) begin n_mis++; $display("FAIL %s_mosi_word: got %h expected %h", name, m_word, exp_word); end
        n_cmp++; if (rises != exp_rises) begin n_mis++; $display("FAIL %s_sclk_rises: got %0d expected %0d", name, rises, exp_rises); end
        n_cmp++; if (per_min != 20 || per_max != 20) begin n_mis++; $display("FAIL %s_sclk_period: got min %0d max %0d expected 20", name, per_min, per_max); end
        n_cmp++; if (rvalid_cnt - rv0 != exp_rv) begin n_mis++; $display("FAIL %s_rvalid_count: got %0d expected %0d", name, rvalid_cnt - rv0, exp_rv); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_mis++; $display("FAIL %s_done_count: got %0d expected 1", name, done_cnt - d0); end
        n_cmp++; if (exp_q.size() != 0) begin n_mis++; $display("FAIL %s_bytes_missing: got %0d left expected 0", name, exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_read_devid();
        exp_q.push_back(DEVID_VALUE);
        check_txn("devid", 1'b1, REG_DEVID, 3'd1, 8'h00, 16'h8000, 360, 1, 16);
    endtask

    task automatic test_write_power_ctl();
        check_txn("write", 1'b0, REG_POWER_CTL, 3'd5, 8'h08, 16'h2D08, 360, 0, 16);
    endtask

    task automatic test_burst(input logic [2:0] len);
        for (int i = 1; i <= 6; i++) exp_q.push_back(8'(i));
        check_txn((len == 3'd6) ? "burst6" : "burst7", 1'b1, REG_DATAX0, len, 8'h00, 16'hF200, 1160, 6, 56);
    endtask

    task automatic test_len_zero();
        exp_q.push_back(DEVID_VALUE);
        check_txn("len0", 1'b1, REG_DEVID, 3'd0, 8'h00, 16'h8000, 360, 1, 16);
    endtask

    task automatic test_back_to_back();
        int cs0, d0, cyc;
        cs0 = cs_falls;
        d0  = done_cnt;
        exp_q.push_back(DEVID_VALUE);
        @(negedge CLK);
        RW = 1'b1; ADDR = REG_DEVID; LEN = 3'd1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        RW = 1'b0; ADDR = REG_POWER_CTL; WDATA = 8'h55;
        cyc = 0;
        while (BUSY === 1'b1 && cyc < 5000) begin
            cyc++;
            START = ((cyc % 7) == 3) && (cyc < 300);
            @(negedge CLK);
        end
        START = 1'b0;
        n_cmp++; if (cyc != 360) begin n_mis++; $display("FAIL collide_busy_cycles: got %0d expected 360", cyc); end
        n_cmp++; if (DONE !== 1'b1) begin n_mis++; $display("FAIL collide_done: got %b expected 1", DONE); end
        // start a second read in the DONE cycle itself
        exp_q.push_back(DEVID_VALUE);
        RW = 1'b1; ADDR = REG_DEVID; LEN = 3'd1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        n_cmp++; if (BUSY !== 1'b1) begin n_mis++; $display("FAIL done_cycle_start_busy: got %b expected 1", BUSY); end
        cyc = 0;
        while (BUSY === 1'b1 && cyc < 5000) begin
            cyc++;
            @(negedge CLK);
        end
        n_cmp++; if (cyc != 360) begin n_mis++; $display("FAIL done_cycle_busy_cycles: got %0d expected 360", cyc); end
        repeat (3) @(negedge CLK);
        n_cmp++; if (cs_falls - cs0 != 2) begin n_mis++; $display("FAIL collide_txn_count: got %0d expected 2", cs_falls - cs0); end
        n_cmp++; if (done_cnt - d0 != 2) begin n_mis++; $display("FAIL collide_done_count: got %0d expected 2", done_cnt - d0); end
        n_cmp++; if (mem[REG_POWER_CTL] !== 8'h08) begin n_mis++; $display("FAIL collide_stray_write: reg 2D got %h expected 08", mem[REG_POWER_CTL]); end
        n_cmp++; if (exp_q.size() != 0) begin n_mis++; $display("FAIL collide_bytes_missing: got %0d expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_mid_shift();
        int cyc, d0, rv0;
        @(negedge CLK);
        RW = 1'b1; ADDR = REG_DEVID; LEN = 3'd1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        cyc = 0;
        while (rises < 5 && cyc < 2000) begin
            cyc++;
            @(negedge CLK);
        end
        n_cmp++; if (rises < 5) begin n_mis++; $display("FAIL midreset_reach_bit5: got %0d rises expected 5", rises); end
        d0  = done_cnt;
        rv0 = rvalid_cnt;
        #2;
        RESET_N = 1'b0;
        #1;
        n_cmp++; if (SPI_CS_N !== 1'b1) begin n_mis++; $display("FAIL midreset_cs_n: got %b expected 1", SPI_CS_N); end
        n_cmp++; if (SPI_SCLK !== 1'b1) begin n_mis++; $display("FAIL midreset_sclk: got %b expected 1", SPI_SCLK); end
        n_cmp++; if (BUSY !== 1'b0) begin n_mis++; $display("FAIL midreset_busy: got %b expected 0", BUSY); end
        n_cmp++; if (RDATA !== 8'h00) begin n_mis++; $display("FAIL midreset_rdata: got %h expected 00", RDATA); end
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (400) @(negedge CLK);
        n_cmp++; if (done_cnt != d0) begin n_mis++; $display("FAIL midreset_no_done: got %0d pulses expected 0", done_cnt - d0); end
        n_cmp++; if (rvalid_cnt != rv0) begin n_mis++; $display("FAIL midreset_no_rvalid: got %0d pulses expected 0", rvalid_cnt - rv0); end
        n_cmp++; if (SPI_CS_N !== 1'b1) begin n_mis++; $display("FAIL midreset_cs_stays_high: got %b expected 1", SPI_CS_N); end
        test_read_devid();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[REG_DEVID] = DEVID_VALUE;
        for (int i = 0; i < 6; i++) mem[REG_DATAX0 + 6'(i)] = 8'(i + 1);
        test_reset();
        test_read_devid();
        test_write_power_ctl();
        test_burst(3'd6);
        test_burst(3'd7);
        test_len_zero();
        test_back_to_back();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
